// File: rtl/vga_timing_detect.sv
`timescale 1ns/1ps
// vga_timing_detect
//   Watches an incoming hs/vs/de stream, measures the video format and
//   recovers each active pixel's position.
//
//   Ports:
//     clk, rst                : pixel clock, async active-high reset
//     I_hs, I_vs, I_de        : incoming sync/enable (polarity set by HS_POL/VS_POL)
//     O_de                    : I_de delayed 2 clocks
//     pos_x, pos_y            : active pixel / line index, aligned with O_de
//     meas_h_total/h_active   : clocks per line / de clocks per line
//     meas_v_total/v_active   : lines per frame / lines containing de
//     meas_valid              : 1-clock pulse when meas_* update
//     locked                  : format stable for LOCK_FRAMES measurements
//     fmt_change              : 1-clock pulse when locked falls
module vga_timing_detect #(
    parameter logic HS_POL      = 1'b1,
    parameter logic VS_POL      = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_hs,
    input  logic        I_vs,
    input  logic        I_de,
    output logic        O_de,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_v_active,
    output logic        meas_valid,
    output logic        locked,
    output logic        fmt_change
);

    localparam logic [11:0] MAX    = 12'hFFF;
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    sync_t       s1, s2;
    logic [11:0] h_cnt, line_len, de_cnt, run_len, line_cnt, act_lines;
    logic        have_line, have_run, frame_err, armed, hs_lost;
    logic [3:0]  match_cnt;

    logic        hs_start, vs_start, de_fall, h_sat;
    logic        len_err, run_err, meas_en, tuple_eq;
    logic [11:0] new_len, new_run;

    always_comb begin
        hs_start = s1.hs & ~s2.hs;
        vs_start = s1.vs & ~s2.vs;
        de_fall  = ~s1.de & s2.de;
        h_sat    = (h_cnt == MAX);
        new_len  = h_sat ? MAX : h_cnt + 12'd1;
        // de_cnt has not yet counted the last high clock of the run
        new_run  = (de_cnt == MAX) ? MAX : de_cnt + 12'd1;
        len_err  = hs_start & have_line & (new_len != line_len);
        run_err  = de_fall & have_run & (new_run != run_len);
        // no measurement while hs is missing; meas_* hold their last value
        meas_en  = vs_start & armed & ~hs_lost & ~h_sat;
        tuple_eq = (line_len  == meas_h_total)  && (run_len   == meas_h_active) &&
                   (line_cnt  == meas_v_total)  && (act_lines == meas_v_active);
    end

    assign O_de = s2.de;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1            <= '0;
            s2            <= '0;
            h_cnt         <= '0;
            line_len      <= '0;
            de_cnt        <= '0;
            run_len       <= '0;
            line_cnt      <= '0;
            act_lines     <= '0;
            have_line     <= 1'b0;
            have_run      <= 1'b0;
            frame_err     <= 1'b0;
            armed         <= 1'b0;
            hs_lost       <= 1'b0;
            match_cnt     <= '0;
            meas_h_total  <= '0;
            meas_h_active <= '0;
            meas_v_total  <= '0;
            meas_v_active <= '0;
            meas_valid    <= 1'b0;
            locked        <= 1'b0;
            fmt_change    <= 1'b0;
            pos_x         <= '0;
            pos_y         <= '0;
        end else begin
            s1 <= {I_hs ~^ HS_POL, I_vs ~^ VS_POL, I_de};
            s2 <= s1;

            // horizontal measurement
            if (hs_start) begin
                line_len <= new_len;
                h_cnt    <= '0;
            end else if (!h_sat) begin
                h_cnt <= h_cnt + 12'd1;
            end
            if (hs_start)   hs_lost <= 1'b0;
            else if (h_sat) hs_lost <= 1'b1;

            if (de_fall) begin
                run_len <= new_run;
                de_cnt  <= '0;
            end else if (s2.de && de_cnt != MAX) begin
                de_cnt <= de_cnt + 12'd1;
            end

            // per-frame state; a coincident hs_start counts as line 1
            if (vs_start) begin
                have_line <= 1'b0;
                have_run  <= 1'b0;
                frame_err <= 1'b0;
                line_cnt  <= {11'd0, hs_start};
                act_lines <= '0;
            end else begin
                if (hs_start) have_line <= 1'b1;
                if (de_fall)  have_run  <= 1'b1;
                if (len_err || run_err || h_sat) frame_err <= 1'b1;
                if (hs_start && line_cnt != MAX)  line_cnt  <= line_cnt + 12'd1;
                if (de_fall && act_lines != MAX)  act_lines <= act_lines + 12'd1;
            end

            // measurement and lock tracking
            armed      <= armed | vs_start;
            meas_valid <= meas_en;
            if (meas_en) begin
                meas_h_total  <= line_len;
                meas_h_active <= run_len;
                meas_v_total  <= line_cnt;
                meas_v_active <= act_lines;
            end

            if (h_sat)
                match_cnt <= '0;
            else if (meas_en)
                match_cnt <= (tuple_eq && !frame_err) ?
                             ((match_cnt == LOCK_N) ? match_cnt : match_cnt + 4'd1) : 4'd0;

            locked     <= (match_cnt == LOCK_N);
            fmt_change <= locked & (match_cnt != LOCK_N);

            // position, loaded alongside s2 so it lines up with O_de;
            // act_lines doubles as the active-line index within the frame
            if (s1.de)
                pos_x <= s2.de ? pos_x + 12'd1 : 12'd0;
            if (s1.de && !s2.de)
                pos_y <= vs_start ? 12'd0 : act_lines;
        end
    end

endmodule
